// File: rtl/endian_swap_arbiter.sv
// Two-requester round-robin endian-conversion engine with a one-entry output buffer.
// Optional per-requester completion counters are enabled by defining SWAP_COUNT_EN.
module endian_swap_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [1:0]        req0_mode,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [1:0]        req1_mode,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state;
    logic              last_grant;
    logic              can_accept;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              take;
    logic [DATA_W-1:0] sel_data;
    logic [1:0]        sel_mode;

    function automatic logic [DATA_W-1:0] permute(input logic [DATA_W-1:0] w,
                                                  input logic [1:0] m);
        logic [DATA_W-1:0] r;
        case (m)
            2'b00:   r = w;
            2'b01:   r = {w[7:0], w[15:8], w[23:16], w[31:24]};
            2'b10:   r = {w[15:8], w[7:0], w[31:24], w[23:16]};
            default: r = {w[23:16], w[31:24], w[7:0], w[15:8]};
        endcase
        return r;
    endfunction

    // Round-robin: on a tie the requester that did not win last gets the grant.
    always_comb begin
        out_valid  = (state == FULL);
        can_accept = ~out_valid | out_ready;
        grant0     = req0_valid & (~req1_valid | last_grant);
        grant1     = req1_valid & (~req0_valid | ~last_grant);
        req0_ready = grant0 & can_accept;
        req1_ready = grant1 & can_accept;
        accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        take       = out_valid & out_ready;
        sel_data   = grant1 ? req1_data : req0_data;
        sel_mode   = grant1 ? req1_mode : req0_mode;
    end

    // Output buffer; a take with a simultaneous accept reloads and stays FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_src    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                state      <= FULL;
                out_data   <= permute(sel_data, sel_mode);
                out_src    <= grant1;
                last_grant <= grant1;
            end else if (take) begin
                state <= EMPTY;
            end
        end
    end

`ifdef SWAP_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (take) begin
            if (out_src) cnt1 <= cnt1 + CNT_W'(1);
            else         cnt0 <= cnt0 + CNT_W'(1);
        end
    end
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_endian_swap_arbiter.sv
// Self-checking bench for endian_swap_arbiter: directed test-plan steps plus random traffic
// checked against a transaction-level model. Define SWAP_COUNT_EN to exercise the counters.
module tb_endian_swap_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_data, req1_data, out_data;
    logic [1:0]  req0_mode, req1_mode;
    logic        out_valid, out_src, out_ready;
    logic [15:0] cnt0, cnt1;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: buffer contents, tie-break memory, completion counts.
    logic        m_valid, m_src, m_last;
    logic [31:0] m_data;
    int          m_cnt0, m_cnt1;

    endian_swap_arbiter #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_mode(req0_mode), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_mode(req1_mode), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Output byte i (from the top) is taken from input byte order[mode][i].
    function automatic logic [31:0] ref_perm(input logic [31:0] w, input logic [1:0] m);
        int order [4][4] = '{'{3, 2, 1, 0}, '{0, 1, 2, 3}, '{1, 0, 3, 2}, '{2, 3, 0, 1}};
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++)
            r[31 - 8*i -: 8] = w[8*order[m][i] +: 8];
        return r;
    endfunction

    task automatic check_outs();
        int e0 = 0, e1 = 0;
`ifdef SWAP_COUNT_EN
        e0 = m_cnt0 % 65536;
        e1 = m_cnt1 % 65536;
`endif
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", out_data, m_data);
        chk("out_src", 32'(out_src), 32'(m_src));
        chk("cnt0", 32'(cnt0), 32'(e0));
        chk("cnt1", 32'(cnt1), 32'(e1));
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_last = 1'b1;
        m_cnt0 = 0; m_cnt1 = 0;
    endtask

    // Async assert checked immediately; release away from the edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_idle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; req0_mode = '0; req1_mode = '0;
    endtask

    // One clock: check handshake readies, advance the model across the edge, check outputs.
    task automatic step();
        logic can, e0, e1;
        #1;
        can = !m_valid || out_ready;
        e0  = can && req0_valid && (!req1_valid || m_last == 1'b1);
        e1  = can && req1_valid && (!req0_valid || m_last == 1'b0);
        chk("req0_ready", 32'(req0_ready), 32'(e0));
        chk("req1_ready", 32'(req1_ready), 32'(e1));
        @(posedge clk);
        if (m_valid && out_ready) begin
            if (m_src) m_cnt1++;
            else       m_cnt0++;
            if (!(e0 || e1)) m_valid = 1'b0;
        end
        if (e0 || e1) begin
            m_valid = 1'b1;
            m_src   = e1;
            m_last  = e1;
            m_data  = e1 ? ref_perm(req1_data, req1_mode) : ref_perm(req0_data, req0_mode);
        end
        #1;
        check_outs();
    endtask

    initial begin
        logic [31:0] sweep [4];
        logic [1:0]  tie_src [4];
        sweep   = '{32'h87654321, 32'h21436587, 32'h43218765, 32'h65872143};
        tie_src = '{2'd0, 2'd1, 2'd0, 2'd1};

        set_idle();
        out_ready = 1'b1;
        do_reset();
        step();

        // Single requester, full reverse.
        req0_valid = 1'b1; req0_data = 32'h12345678; req0_mode = 2'b01;
        #1;
        chk("single_ready", 32'(req0_ready), 32'd1);
        step();
        chk("single_data", out_data, 32'h78563412);
        set_idle();
        step();

        // Mode sweep on requester 1.
        for (int m = 0; m < 4; m++) begin
            req1_valid = 1'b1; req1_data = 32'h87654321; req1_mode = 2'(m);
            step();
            chk("sweep_data", out_data, sweep[m]);
            chk("sweep_src", 32'(out_src), 32'd1);
        end
        set_idle();

        // Tie after reset alternates starting with requester 0.
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 32'hA0A1A2A3; req1_data = 32'hB0B1B2B3;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("tie_src", 32'(out_src), 32'(tie_src[i]));
        end
        set_idle();
        step();

        // Backpressure: buffer held while both request, then reload without a bubble.
        req0_valid = 1'b1; req0_data = 32'h12345678; req0_mode = 2'b01;
        step();
        req1_valid = 1'b1; req1_data = 32'hCAFEF00D; req1_mode = 2'b10;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold", out_data, 32'h78563412);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_any", 32'(req0_ready | req1_ready), 32'd1);
        step();
        chk("bp_reload_valid", 32'(out_valid), 32'd1);

        // Reset while FULL, then the first tie goes to requester 0.
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        step();
        chk("post_reset_tie", 32'(out_src), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            req0_valid = 1'($urandom); req1_valid = 1'($urandom);
            req0_data  = $urandom;     req1_data  = $urandom;
            req0_mode  = 2'($urandom); req1_mode  = 2'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        set_idle();
        out_ready = 1'b1;

        // Counters: 3 from requester 0, 2 from requester 1.
        do_reset();
        req0_valid = 1'b1; req0_data = 32'h01020304;
        repeat (3) step();
        req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 32'h05060708;
        repeat (2) step();
        set_idle();
        step();
`ifdef SWAP_COUNT_EN
        chk("cnt0_three", 32'(cnt0), 32'd3);
        chk("cnt1_two", 32'(cnt1), 32'd2);
        req0_valid = 1'b1;
        repeat (65532) step();
        set_idle();
        step();
        chk("cnt0_max", 32'(cnt0), 32'h0000FFFF);
        req0_valid = 1'b1;
        step();
        set_idle();
        step();
        chk("cnt0_wrap", 32'(cnt0), 32'd0);
`else
        chk("cnt0_off", 32'(cnt0), 32'd0);
        chk("cnt1_off", 32'(cnt1), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
